imem_fetch_stage: RTL

//   Instruction-fetch stage fed directly by the PC counter. Uses pc_in as the

---
 rtl/imem_fetch_stage_if.sv | 31 +++
 rtl/imem_fetch_stage.sv | 112 +++++++++++
 2 files changed

// File: rtl/imem_fetch_stage_if.sv
// imem_fetch_stage_if: fetch control, host IMEM write port and decode-side handshake
// master drives the fetch stage, slave is the fetch stage itself
interface imem_fetch_stage_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] pc_in;
    logic              flush;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [DATA_W-1:0] imem_wdata;
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              fetch_ready;
    logic              overflow;
    logic [7:0]        drop_cnt;
    logic              parity_err;

    modport master (
        output start, pc_in, flush, imem_we, imem_waddr, imem_wdata, if_ready,
        input  if_valid, if_instr, if_pc, fetch_ready, overflow, drop_cnt, parity_err
    );

    modport slave (
        input  start, pc_in, flush, imem_we, imem_waddr, imem_wdata, if_ready,
        output if_valid, if_instr, if_pc, fetch_ready, overflow, drop_cnt, parity_err
    );
endinterface

// File: rtl/imem_fetch_stage.sv
// imem_fetch_stage: PC-addressed synchronous IMEM read feeding a PC-tagged fetch FIFO
// Optional IMEM_PARITY_EN keeps an even-parity bit per IMEM word and flags bad head entries.
module imem_fetch_stage #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    imem_fetch_stage_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] FR_MAX = CW'(FIFO_DEPTH - 2);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata;
    logic              inflight;
    logic [ADDR_W-1:0] tag;
    logic [DATA_W-1:0] q_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] q_pc [FIFO_DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic              ovf;
    logic [7:0]        drops;
    logic              push;
    logic              pop;
    logic              accept;
    logic              drop;
    logic              valid;

`ifdef IMEM_PARITY_EN
    logic mem_par [2**ADDR_W];
    logic rerr;
    logic q_err [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            mem[bus.imem_waddr]     <= bus.imem_wdata;
            mem_par[bus.imem_waddr] <= ^bus.imem_wdata;
        end
        if (bus.start) begin
            rdata <= mem[bus.pc_in];
            rerr  <= (^mem[bus.pc_in]) ^ mem_par[bus.pc_in];
        end
    end

    always_ff @(posedge clk)
        if (accept) q_err[wptr] <= rerr;

    assign bus.parity_err = valid & q_err[rptr];
`else
    // Read-first falls out of the non-blocking write racing the registered read
    always_ff @(posedge clk) begin
        if (bus.imem_we) mem[bus.imem_waddr] <= bus.imem_wdata;
        if (bus.start) rdata <= mem[bus.pc_in];
    end

    assign bus.parity_err = 1'b0;
`endif

    assign valid  = count != '0;
    assign pop    = valid & bus.if_ready & ~bus.flush;
    assign push   = inflight & ~bus.flush;
    assign accept = push & ((count != FULL) | pop);
    assign drop   = push & (count == FULL) & ~pop;

    always_ff @(posedge clk) begin
        if (accept) begin
            q_data[wptr] <= rdata;
            q_pc[wptr]   <= tag;
        end
    end

    // A read issued on a flush edge survives: only the older in-flight word is discarded
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
            tag      <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            drops    <= '0;
        end else begin
            inflight <= bus.start;
            if (bus.start) tag <= bus.pc_in;
            if (bus.flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (accept) wptr <= wptr + PW'(1);
                if (pop) rptr <= rptr + PW'(1);
                count <= count + CW'(accept) - CW'(pop);
            end
            if (drop) begin
                ovf <= 1'b1;
                if (drops != 8'hFF) drops <= drops + 8'd1;
            end
        end
    end

    assign bus.if_valid    = valid;
    assign bus.if_instr    = valid ? q_data[rptr] : '0;
    assign bus.if_pc       = valid ? q_pc[rptr] : '0;
    assign bus.fetch_ready = count <= FR_MAX;
    assign bus.overflow    = ovf;
    assign bus.drop_cnt    = drops;
endmodule
